alu_arbiter: RTL and testbench

//  Shares the single EXU ALU (ADD / ADD_JALR) between two requesters: port 0 = EXU operand path, port 1 = LSU address gen.

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one add/add_jalr ALU between the EXU operand path (port 0)
// and the LSU address generator (port 1). Round-robin grant on contention and a
// one-entry registered response stage with valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | response register holds nothing, rsp_valid = 0
// FULL  | response register holds a result for port rsp_id, rsp_valid = 1

module alu_arbiter #(
    parameter int              BW            = 64,
    parameter int              ALUC_W        = 4,
    parameter logic [ALUC_W-1:0] ALUC_ADD      = 4'd0,
    parameter logic [ALUC_W-1:0] ALUC_ADD_JALR = 4'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ALUC_W-1:0] req0_aluc,
    input  logic [BW-1:0]     req0_num1,
    input  logic [BW-1:0]     req0_num2,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ALUC_W-1:0] req1_aluc,
    input  logic [BW-1:0]     req1_num1,
    input  logic [BW-1:0]     req1_num2,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [BW-1:0]     rsp_result
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              can_accept;
    logic              grant;
    logic              accept0;
    logic              accept1;
    logic [BW-1:0]     alu0;
    logic [BW-1:0]     alu1;

    // Shared ALU; every opcode other than ADD_JALR behaves as a plain add.
    function automatic logic [BW-1:0] alu(input logic [ALUC_W-1:0] aluc,
                                          input logic [BW-1:0]     num1,
                                          input logic [BW-1:0]     num2);
        logic [BW-1:0] sum;
        logic [BW-1:0] res;
        sum = num1 + num2;
        case (aluc)
            ALUC_ADD:      res = sum;
            ALUC_ADD_JALR: begin
                res    = sum;
                res[0] = 1'b0;
            end
            default:       res = sum;
        endcase
        return res;
    endfunction

    assign alu0 = alu(req0_aluc, req0_num1, req0_num2);
    assign alu1 = alu(req1_aluc, req1_num1, req1_num2);

    // Grant selection and ready generation; readies are forced low during reset.
    always_comb begin
        can_accept = rst_n && !flush && ((state == EMPTY) || rsp_ready);
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        req0_ready = can_accept && (grant == 1'b0);
        req1_ready = can_accept && (grant == 1'b1);
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
    end

    assign rsp_valid = (state == FULL);

    // Response stage FSM with registered result, id and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept0) begin
                state      <= FULL;
                rsp_id     <= 1'b0;
                rsp_result <= alu0;
                last_grant <= 1'b0;
            end else if (accept1) begin
                state      <= FULL;
                rsp_id     <= 1'b1;
                rsp_result <= alu1;
                last_grant <= 1'b1;
            end else if (flush || ((state == FULL) && rsp_ready)) begin
                state      <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table, reset corner case and randomized traffic
// against a transaction-level reference model of the arbiter.

module tb_alu_arbiter;

    localparam int          BW     = 64;
    localparam int          ALUC_W = 4;
    localparam logic [3:0]  OP_ADD  = 4'd0;
    localparam logic [3:0]  OP_JALR = 4'd1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [ALUC_W-1:0] req0_aluc = '0, req1_aluc = '0;
    logic [BW-1:0]     req0_num1 = '0, req0_num2 = '0, req1_num1 = '0, req1_num2 = '0;
    logic              rsp_valid, rsp_id;
    logic              rsp_ready = 1'b0;
    logic [BW-1:0]     rsp_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .BW(BW), .ALUC_W(ALUC_W), .ALUC_ADD(OP_ADD), .ALUC_ADD_JALR(OP_JALR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluc(req0_aluc),
        .req0_num1(req0_num1), .req0_num2(req0_num2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluc(req1_aluc),
        .req1_num1(req1_num1), .req1_num2(req1_num2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v0; logic [3:0] a0; logic [63:0] x0; logic [63:0] y0;
        logic        v1; logic [3:0] a1; logic [63:0] x1; logic [63:0] y1;
        logic        rr; logic fl;
        logic        chk_rdy; logic r0; logic r1;
        logic        nv; logic nid; logic [63:0] nres;
    } vec_t;

    vec_t vecs[14];

    // Reference model state: what the response register should hold.
    logic        m_valid;
    logic        m_id;
    logic [63:0] m_result;
    int          m_last;

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] s;
        s = a + b;
        if (op == OP_JALR) s = s & ~64'd1;
        return s;
    endfunction

    task automatic apply(input vec_t t);
        req0_valid = t.v0; req0_aluc = t.a0; req0_num1 = t.x0; req0_num2 = t.y0;
        req1_valid = t.v1; req1_aluc = t.a1; req1_num1 = t.x1; req1_num2 = t.y1;
        rsp_ready  = t.rr; flush = t.fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_last = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] all_ones;
        logic [63:0] held;
        int          winner;
        logic        e_can, e_r0, e_r1;
        logic        take0, take1;
        all_ones = '1;

        //            v0 a0       x0            y0  v1 a1       x1             y1  rr fl chk r0 r1 nv id res
        vecs[0]  = '{1, OP_ADD,  64'd5,        64'd7, 0, OP_ADD, 0, 0,               1, 0, 1, 1, 0, 1, 0, 64'd12};
        vecs[1]  = '{0, OP_ADD,  0, 0,                1, OP_JALR, 64'h8000_0003, 64'h2, 1, 0, 1, 0, 1, 1, 1, 64'h8000_0004};
        vecs[2]  = '{1, OP_ADD,  all_ones,     64'd1, 0, OP_ADD, 0, 0,               1, 0, 1, 1, 0, 1, 0, 64'd0};
        vecs[3]  = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    1, 0, 1, 0, 1, 1, 1, 64'd100};
        vecs[4]  = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    1, 0, 1, 1, 0, 1, 0, 64'd30};
        vecs[5]  = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    1, 0, 1, 0, 1, 1, 1, 64'd100};
        vecs[6]  = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    1, 0, 1, 1, 0, 1, 0, 64'd30};
        vecs[7]  = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    0, 0, 1, 0, 0, 1, 0, 64'd30};
        vecs[8]  = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    0, 0, 1, 0, 0, 1, 0, 64'd30};
        vecs[9]  = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    0, 0, 1, 0, 0, 1, 0, 64'd30};
        vecs[10] = '{1, OP_ADD,  64'd10,      64'd20, 1, OP_JALR, 64'd100, 64'd1,    1, 0, 1, 0, 1, 1, 1, 64'd100};
        vecs[11] = '{1, 4'd7,    64'd40,       64'd2, 0, OP_ADD, 0, 0,               0, 1, 1, 0, 0, 0, 0, 64'd0};
        vecs[12] = '{1, 4'd7,    64'd40,       64'd2, 1, OP_JALR, 64'd100, 64'd1,    0, 0, 1, 1, 0, 1, 0, 64'd42};
        vecs[13] = '{0, OP_ADD,  0, 0,                0, OP_ADD, 0, 0,               1, 0, 0, 0, 0, 0, 0, 64'd0};

        // Reset values, readies held low while in reset even with requests present.
        do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
        check("reset_rsp_result", rsp_result, 64'd0);
        check("reset_ready0", {63'd0, req0_ready}, 64'd0);
        check("reset_ready1", {63'd0, req1_ready}, 64'd0);
        do_reset();

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            if (vecs[i].chk_rdy) begin
                check($sformatf("vec%0d_ready0", i), {63'd0, req0_ready}, {63'd0, vecs[i].r0});
                check($sformatf("vec%0d_ready1", i), {63'd0, req1_ready}, {63'd0, vecs[i].r1});
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rsp_valid", i), {63'd0, rsp_valid}, {63'd0, vecs[i].nv});
            if (vecs[i].nv) begin
                check($sformatf("vec%0d_rsp_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].nid});
                check($sformatf("vec%0d_rsp_result", i), rsp_result, vecs[i].nres);
            end
            if (i >= 7 && i <= 9) begin
                held = rsp_result;
                check($sformatf("vec%0d_stall_stable", i), held, 64'd30);
            end
        end

        // Async reset mid-cycle while FULL, then port 0 wins the first tie.
        @(negedge clk);
        apply('{1, OP_ADD, 64'd1, 64'd1, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(posedge clk);
        #1;
        check("async_pre_full", {63'd0, rsp_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("async_rsp_result", rsp_result, 64'd0);
        check("async_ready0", {63'd0, req0_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply('{1, OP_ADD, 64'd3, 64'd4, 1, OP_ADD, 64'd9, 64'd9, 1, 0, 0, 0, 0, 0, 0, 0});
        #1;
        check("post_reset_tie_ready0", {63'd0, req0_ready}, 64'd1);
        check("post_reset_tie_ready1", {63'd0, req1_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("post_reset_tie_id", {63'd0, rsp_id}, 64'd0);
        check("post_reset_tie_result", rsp_result, 64'd7);

        // Randomized traffic against the reference model.
        do_reset();
        take0 = 1'b0; take1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!req0_valid || take0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_aluc  = ($urandom_range(0, 2) == 0) ? OP_JALR : 4'($urandom_range(0, 15));
                req0_num1  = {$urandom(), $urandom()};
                req0_num2  = {$urandom(), $urandom()};
            end
            if (!req1_valid || take1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_aluc  = ($urandom_range(0, 1) == 0) ? OP_JALR : OP_ADD;
                req1_num1  = {$urandom(), $urandom()};
                req1_num2  = {$urandom(), $urandom()};
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            #1;
            // Expected grant: a lone requester wins; on a tie the port not served last wins.
            e_can  = !flush && (!m_valid || rsp_ready);
            if (req0_valid && req1_valid) winner = 1 - m_last;
            else if (req1_valid)          winner = 1;
            else                          winner = 0;
            e_r0 = e_can && req0_valid && winner == 0;
            e_r1 = e_can && req1_valid && winner == 1;
            if (req0_valid || req1_valid) begin
                check("rand_ready0", {63'd0, req0_ready}, {63'd0, e_r0});
                check("rand_ready1", {63'd0, req1_ready}, {63'd0, e_r1});
            end else begin
                check("rand_idle_one_hot", {63'd0, req0_ready && req1_ready}, 64'd0);
            end
            take0 = e_r0;
            take1 = e_r1;
            @(posedge clk);
            #1;
            if (take0) begin
                m_valid = 1'b1; m_id = 1'b0; m_last = 0;
                m_result = ref_alu(req0_aluc, req0_num1, req0_num2);
            end else if (take1) begin
                m_valid = 1'b1; m_id = 1'b1; m_last = 1;
                m_result = ref_alu(req1_aluc, req1_num1, req1_num2);
            end else if (flush || rsp_ready) begin
                m_valid = 1'b0;
            end
            check("rand_rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
            if (m_valid) begin
                check("rand_rsp_id", {63'd0, rsp_id}, {63'd0, m_id});
                check("rand_rsp_result", rsp_result, m_result);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
